// File: rtl/op_pkg.sv
// op_pkg: operation byte codes and scheduler state encoding shared by the command scheduler
package op_pkg;
    localparam logic [7:0] OPERATE_IGNORE   = 8'h00;
    localparam logic [7:0] OPERATE_GET      = 8'h01;
    localparam logic [7:0] OPERATE_PUT      = 8'h02;
    localparam logic [7:0] OPERATE_THROW    = 8'h03;
    localparam logic [7:0] OPERATE_INTERACT = 8'h04;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } sched_state_t;
endpackage

// File: rtl/op_fifo.sv
// op_fifo: DEPTH x 8 command FIFO; callers never write when full nor pop when empty
module op_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign head  = mem[rd_ptr];
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;

    // storage array; occupancy alone decides which entries are meaningful
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(wr_en) - CW'(pop);
        end
    end
endmodule

// File: rtl/operate_cmd_scheduler.sv
// operate_cmd_scheduler: arbitrates manual/script ops into a FIFO and issues them one at a time; OP_COOLDOWN_EN adds an idle gap after each command
import op_pkg::*;

module operate_cmd_scheduler #(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             man_op,
    input  logic                   script_en,
    input  logic                   scr_valid,
    input  logic [7:0]             scr_op,
    output logic                   scr_ready,
    output logic                   tx_valid,
    output logic [7:0]             tx_data,
    input  logic                   tx_ready,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [7:0]             drop_cnt
);
    sched_state_t state;
    logic         man_req;
    logic         wr_en;
    logic         pop;
    logic         full;
    logic         empty;
    logic [7:0]   head;

    assign man_req   = man_op != OPERATE_IGNORE;
    assign scr_ready = rst_n & script_en & ~man_req & ~full;
    assign wr_en     = (man_req & ~full) | (scr_valid & scr_ready & (scr_op != OPERATE_IGNORE));
    assign pop       = (state == ST_IDLE) & ~empty;
    assign tx_valid  = state == ST_SEND;

    op_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (man_req ? man_op : scr_op),
        .pop     (pop),
        .head    (head),
        .count   (fifo_count),
        .full    (full),
        .empty   (empty)
    );

    // manual requests have no backpressure, so overflow is only counted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt <= '0;
        else if (man_req && full && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end

`ifdef OP_COOLDOWN_EN
    localparam int GW = $clog2(GAP_CYCLES + 1);

    logic [GW-1:0] gap_cnt;

    // issue FSM: pop into tx_data, hold until accepted, then stay quiet for GAP_CYCLES
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            tx_data <= '0;
            gap_cnt <= '0;
        end else if (pop) begin
            tx_data <= head;
            state   <= ST_SEND;
        end else if (state == ST_SEND && tx_ready) begin
            state   <= ST_GAP;
            gap_cnt <= GW'(GAP_CYCLES - 1);
        end else if (state == ST_GAP) begin
            if (gap_cnt == '0) state <= ST_IDLE;
            else gap_cnt <= gap_cnt - GW'(1);
        end
    end
`else
    // issue FSM: pop into tx_data, hold until accepted, then return straight to idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            tx_data <= '0;
        end else if (pop) begin
            tx_data <= head;
            state   <= ST_SEND;
        end else if (state == ST_SEND && tx_ready) begin
            state   <= ST_IDLE;
        end
    end
`endif
endmodule

// File: tb/tb_operate_cmd_scheduler.sv
// tb_operate_cmd_scheduler: randomized and directed bench with a cycle-timed reference model and a handshake scoreboard
import op_pkg::*;

module tb_operate_cmd_scheduler;
    localparam int DEPTH      = 4;
    localparam int GAP_CYCLES = 16;
`ifdef OP_COOLDOWN_EN
    localparam int GAP = GAP_CYCLES;
`else
    localparam int GAP = 0;
`endif

    logic       clk = 0;
    logic       rst_n = 0;
    logic [7:0] man_op = 0;
    logic       script_en = 0;
    logic       scr_valid = 0;
    logic [7:0] scr_op = 0;
    logic       scr_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready = 0;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [7:0] drop_cnt;

    operate_cmd_scheduler #(.DEPTH(DEPTH), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .man_op     (man_op),
        .script_en  (script_en),
        .scr_valid  (scr_valid),
        .scr_op     (scr_op),
        .scr_ready  (scr_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .fifo_count (fifo_count),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] sb[$];
    logic [7:0] mq[$];
    bit         sending = 0;
    int         free_at = 0;
    int         cyc = 0;
    int         drops = 0;

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // scoreboard consumer: every accepted handshake must deliver the oldest expected byte
    task automatic monitor();
        logic [7:0] last = 0;
        bit held = 0;
        forever begin
            @(negedge clk);
            if (rst_n && tx_valid) begin
                if (held) chk("tx_data_stable", int'(tx_data), int'(last));
                if (tx_ready) begin
                    if (sb.size() == 0) chk("unexpected_tx", 1, 0);
                    else chk("tx_data", int'(tx_data), int'(sb.pop_front()));
                    held = 0;
                end else begin
                    held = 1;
                    last = tx_data;
                end
            end else begin
                held = 0;
            end
        end
    endtask

    // one clock cycle: drive inputs, check outputs against the model, advance the model
    task automatic step(logic [7:0] m, logic se, logic sv, logic [7:0] so, logic rdy);
        int sz;
        bit e_sr;
        bit was_send;
        man_op = m; script_en = se; scr_valid = sv; scr_op = so; tx_ready = rdy;
        @(negedge clk);
        sz = mq.size();
        e_sr = se && m == 0 && sz < DEPTH;
        chk("scr_ready", int'(scr_ready), int'(e_sr));
        chk("tx_valid", int'(tx_valid), int'(sending));
        chk("fifo_count", int'(fifo_count), sz);
        chk("drop_cnt", int'(drop_cnt), drops);
        was_send = sending;
        if (sending && rdy) begin
            sending = 0;
            free_at = cyc + 1 + GAP;
        end
        if (!was_send && cyc >= free_at && sz > 0) begin
            void'(mq.pop_front());
            sending = 1;
        end
        if (m != 0) begin
            if (sz < DEPTH) begin
                mq.push_back(m);
                sb.push_back(m);
            end else if (drops < 255) begin
                drops++;
            end
        end else if (sv && e_sr && so != 0) begin
            mq.push_back(so);
            sb.push_back(so);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // asynchronous reset applied between edges; outputs must clear at once
    task automatic do_reset(int hold);
        man_op = 0; script_en = 1; scr_valid = 1; scr_op = OPERATE_GET; tx_ready = 1;
        rst_n = 0;
        #1;
        chk("rst_tx_valid", int'(tx_valid), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_fifo_count", int'(fifo_count), 0);
        chk("rst_drop_cnt", int'(drop_cnt), 0);
        chk("rst_scr_ready", int'(scr_ready), 0);
        mq.delete();
        sb.delete();
        sending = 0;
        free_at = 0;
        drops = 0;
        repeat (hold) @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        logic [7:0] m;
        logic [7:0] so;
        fork
            monitor();
        join_none
        @(posedge clk);
        #1;
        do_reset(2);
        repeat (5) step(0, 0, 0, 0, 1);
        step(OPERATE_PUT, 0, 0, 0, 1);
        repeat (6) step(0, 0, 0, 0, 1);
        step(OPERATE_THROW, 1, 1, OPERATE_GET, 1);
        step(0, 1, 1, OPERATE_GET, 1);
        repeat (45) step(0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) step(8'(i % 4 + 1), 0, 0, 0, 0);
        repeat (5) step(0, 0, 0, 0, 0);
        repeat (100) step(0, 0, 0, 0, 1);
        repeat (10) step(0, 0, 1, OPERATE_PUT, 1);
        step(OPERATE_PUT, 0, 0, 0, 0);
        step(OPERATE_GET, 0, 0, 0, 0);
        step(OPERATE_THROW, 0, 0, 0, 0);
        step(OPERATE_INTERACT, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0);
        do_reset(1);
        repeat (10) step(0, 0, 0, 0, 1);
        repeat (3000) begin
            m  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            so = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            step(m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), so, 1'($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 999) == 0) do_reset(1);
        end
        repeat (200) step(0, 0, 0, 0, 1);
        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
